// File: rtl/sva_mon_pkg.sv
// Shared types and helpers for the implication monitor: consequent edge modes,
// the delay limit and a saturating adder for the pass/fail counters.
package sva_mon_pkg;

  typedef enum logic [1:0] {
    EM_ROSE    = 2'd0,
    EM_FELL    = 2'd1,
    EM_STABLE  = 2'd2,
    EM_CHANGED = 2'd3
  } edge_mode_e;

  localparam int MAX_DELAY = 8;

  // The sum is clamped to 2**w-1 (w <= 32), so the counters never wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/sampled_value_unit.sv
// One lane's sampled-value history: past value of sig, the edge flags of the
// current sampling edge, the selected f() result and the registered flags.
module sampled_value_unit
  import sva_mon_pkg::*;
#(
  parameter bit PAST_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  edge_mode_e mode_i,
  input  logic       sig_i,
  output logic       match_now_o,
  output logic       rose_o,
  output logic       fell_o,
  output logic       stable_o
);

  logic past_q, past_d;
  logic rose_q, rose_d;
  logic fell_q, fell_d;
  logic stable_q, stable_d;
  logic rose_now, fell_now, stable_now;

  // Flags of the edge being sampled right now, from the settled sig_i.
  assign rose_now   = ~past_q & sig_i;
  assign fell_now   = past_q & ~sig_i;
  assign stable_now = past_q ~^ sig_i;

  always_comb begin
    match_now_o = 1'b0;
    case (mode_i)
      EM_ROSE:    match_now_o = rose_now;
      EM_FELL:    match_now_o = fell_now;
      EM_STABLE:  match_now_o = stable_now;
      EM_CHANGED: match_now_o = ~stable_now;
      default:    match_now_o = 1'b0;
    endcase
  end

  always_comb begin
    past_d   = past_q;
    rose_d   = rose_q;
    fell_d   = fell_q;
    stable_d = stable_q;
    if (en) begin
      past_d   = sig_i;
      rose_d   = rose_now;
      fell_d   = fell_now;
      stable_d = stable_now;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      past_q   <= PAST_INIT;
      rose_q   <= 1'b0;
      fell_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      past_q   <= past_d;
      rose_q   <= rose_d;
      fell_q   <= fell_d;
      stable_q <= stable_d;
    end
  end

  assign rose_o   = rose_q;
  assign fell_o   = fell_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/sva_implication_monitor.sv
// Golden model of "ante |-> ##DELAY f(sig)": per-lane attempt pipes, registered
// pass/fail pulses and saturating totals across all lanes.
module sva_implication_monitor
  import sva_mon_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int DELAY     = 1,
  parameter int CNT_W     = 16,
  parameter int PAST_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             disable_i,
  input  edge_mode_e       mode_i,
  input  logic [LANES-1:0] ante_i,
  input  logic [LANES-1:0] sig_i,
  output logic [LANES-1:0] rose_o,
  output logic [LANES-1:0] fell_o,
  output logic [LANES-1:0] stable_o,
  output logic [LANES-1:0] pass_o,
  output logic [LANES-1:0] fail_o,
  output logic [LANES-1:0] pending_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o
);

  logic [LANES-1:0] match_now;
  logic [LANES-1:0] done;
  logic [LANES-1:0] pend;
  logic [LANES-1:0] pass_q, pass_d;
  logic [LANES-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [31:0]      pass_inc, fail_inc;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sampled_value_unit #(
      .PAST_INIT(PAST_INIT != 0)
    ) u_svu (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode_i     (mode_i),
      .sig_i      (sig_i[l]),
      .match_now_o(match_now[l]),
      .rose_o     (rose_o[l]),
      .fell_o     (fell_o[l]),
      .stable_o   (stable_o[l])
    );

    if (DELAY == 0) begin : g_overlap
      // Overlapping implication: the attempt completes on its own edge.
      assign done[l] = ante_i[l];
      assign pend[l] = 1'b0;
    end else begin : g_pipe
      // Bit i holds an antecedent captured i+1 sampling edges ago.
      logic [DELAY-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d = pipe_q;
        if (en) begin
          pipe_d = disable_i ? '0 : ((pipe_q << 1) | DELAY'(ante_i[l]));
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
      end

      assign done[l] = pipe_q[DELAY-1];
      assign pend[l] = |pipe_q;
    end
  end

  // Completions are suppressed on disabled edges; non-sampling edges clear pulses.
  always_comb begin
    pass_d = '0;
    fail_d = '0;
    if (en && !disable_i) begin
      pass_d = done & match_now;
      fail_d = done & ~match_now;
    end
    pass_inc = '0;
    fail_inc = '0;
    for (int l = 0; l < LANES; l++) begin
      pass_inc = pass_inc + 32'(pass_d[l]);
      fail_inc = fail_inc + 32'(fail_d[l]);
    end
    pass_cnt_d = CNT_W'(sat_add(32'(pass_cnt_q), pass_inc, CNT_W));
    fail_cnt_d = CNT_W'(sat_add(32'(fail_cnt_q), fail_inc, CNT_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q     <= '0;
      fail_q     <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_o     = pass_q;
  assign fail_o     = fail_q;
  assign pending_o  = pend;
  assign pass_cnt_o = pass_cnt_q;
  assign fail_cnt_o = fail_cnt_q;

endmodule
